// File: rtl/vrf_pkg.sv
// Shared defaults, index-width helpers and streamer state encoding for the
// vector register file with streaming engines.
package vrf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREG   = 8;
  localparam int DEF_NELEM  = 64;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } stream_state_e;

endpackage

// File: rtl/vrf_stream_seq.sv
// Element sequencer for one streaming engine: latches register/length on start,
// walks the element counter on each accepted beat and pulses done at the end.
module vrf_stream_seq
  import vrf_pkg::*;
#(
  parameter int  NELEM = DEF_NELEM,
  parameter int  TAG_W = 3,
  localparam int EW    = idx_w(NELEM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             advance,
  input  logic [EW:0]      vl,
  input  logic [TAG_W-1:0] tag_in,
  output logic             busy,
  output logic             last,
  output logic             done,
  output logic             load,
  output logic [EW-1:0]    cnt,
  output logic [EW-1:0]    cnt_nxt,
  output logic [TAG_W-1:0] tag,
  output logic [TAG_W-1:0] tag_nxt
);

  localparam logic [EW:0]   MAX_VL = (EW + 1)'(NELEM);
  localparam logic [EW:0]   ONE_L  = (EW + 1)'(1);
  localparam logic [EW-1:0] ONE_C  = EW'(1);

  stream_state_e state, state_nxt;
  logic [EW:0]   len, len_nxt, vl_eff;
  logic          done_nxt;

  assign vl_eff = (vl > MAX_VL) ? MAX_VL : vl;
  assign busy   = (state == ST_ACTIVE);
  assign last   = busy && ({1'b0, cnt} == (len - ONE_L));

  // NOTE: every output of this block gets a default first so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len;
    tag_nxt   = tag;
    done_nxt  = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_nxt = '0;
          tag_nxt = tag_in;
          len_nxt = vl_eff;
          if (vl_eff == '0) done_nxt  = 1'b1;
          else              state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (advance) begin
          load = 1'b1;
          if (last) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + ONE_C;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      len   <= '0;
      tag   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      len   <= len_nxt;
      tag   <= tag_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: rtl/vector_regfile_stream.sv
// Vector register file with a registered scalar port, a read streamer and a
// masked write streamer, both using valid/ready element handshakes.
module vector_regfile_stream
  import vrf_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  NREG     = DEF_NREG,
  parameter int  NELEM    = DEF_NELEM,
  parameter int  IOTA_REG = 1,
  localparam int VW       = idx_w(NREG),
  localparam int EW       = idx_w(NELEM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_we,
  input  logic [VW-1:0]     s_vreg,
  input  logic [EW-1:0]     s_idx,
  input  logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_err,
  input  logic [EW:0]       vl,
  input  logic              rd_start,
  input  logic [VW-1:0]     rd_vreg,
  output logic              rd_busy,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [EW-1:0]     rd_idx,
  output logic              rd_last,
  output logic              rd_done,
  input  logic              wr_start,
  input  logic [VW-1:0]     wr_vreg,
  output logic              wr_busy,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_mask,
  output logic              wr_done
);

  localparam int MEM_W = NREG * NELEM * DATA_W;

  function automatic logic [MEM_W-1:0] power_up_image();
    logic [MEM_W-1:0] img;
    img = '0;
    for (int e = 0; e < NELEM; e++)
      img[(IOTA_REG * NELEM + e) * DATA_W +: DATA_W] = DATA_W'(e);
    return img;
  endfunction

  function automatic int base(input logic [VW-1:0] v, input logic [EW-1:0] e);
    return (int'(v) * NELEM + int'(e)) * DATA_W;
  endfunction

  // Flat storage image; the iota register content comes from its initial value.
  logic [MEM_W-1:0] mem = power_up_image();

  logic [EW-1:0] rd_cnt_nxt, wr_cnt;
  logic [VW-1:0] rd_tag, rd_tag_nxt, wr_tag;
  logic          rd_load;
  logic          wr_last, wr_load;
  logic [EW-1:0] wr_cnt_nxt;
  logic [VW-1:0] wr_tag_nxt;
  logic          unused_wr;

  vrf_stream_seq #(.NELEM(NELEM), .TAG_W(VW)) u_rd_seq (
    .clk, .reset,
    .start   (rd_start),
    .advance (rd_ready),
    .vl,
    .tag_in  (rd_vreg),
    .busy    (rd_busy),
    .last    (rd_last),
    .done    (rd_done),
    .load    (rd_load),
    .cnt     (rd_idx),
    .cnt_nxt (rd_cnt_nxt),
    .tag     (rd_tag),
    .tag_nxt (rd_tag_nxt)
  );

  vrf_stream_seq #(.NELEM(NELEM), .TAG_W(VW)) u_wr_seq (
    .clk, .reset,
    .start   (wr_start),
    .advance (wr_valid),
    .vl,
    .tag_in  (wr_vreg),
    .busy    (wr_busy),
    .last    (wr_last),
    .done    (wr_done),
    .load    (wr_load),
    .cnt     (wr_cnt),
    .cnt_nxt (wr_cnt_nxt),
    .tag     (wr_tag),
    .tag_nxt (wr_tag_nxt)
  );

  assign unused_wr = ^{wr_last, wr_load, wr_cnt_nxt, wr_tag_nxt, rd_tag};
  assign rd_valid  = rd_busy;
  assign wr_ready  = wr_busy;

  // NOTE: storage has no reset branch; reset only suppresses writes so data
  // already stored survives and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (s_we && !wr_busy)
        mem[base(s_vreg, s_idx) +: DATA_W] <= s_wdata;
      if (wr_busy && wr_valid && wr_mask)
        mem[base(wr_tag, wr_cnt) +: DATA_W] <= wr_data;
    end
  end

  // Reads sample pre-edge storage, so a same-edge write is seen one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s_rdata <= '0;
      s_err   <= 1'b0;
      rd_data <= '0;
    end else begin
      s_rdata <= mem[base(s_vreg, s_idx) +: DATA_W];
      s_err   <= s_we && wr_busy;
      if (rd_load)
        rd_data <= mem[base(rd_tag_nxt, rd_cnt_nxt) +: DATA_W];
    end
  end

endmodule

// File: tb/tb_vector_regfile_stream.sv
// Randomised self-checking bench: a plain array model of the register file
// predicts scalar reads, stream data, handshakes and completion pulses.
module tb_vector_regfile_stream;

  localparam int DATA_W   = 32;
  localparam int NREG     = 8;
  localparam int NELEM    = 64;
  localparam int IOTA_REG = 1;
  localparam int VW       = 3;
  localparam int EW       = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              s_we = 1'b0;
  logic [VW-1:0]     s_vreg = '0;
  logic [EW-1:0]     s_idx = '0;
  logic [DATA_W-1:0] s_wdata = '0;
  logic [DATA_W-1:0] s_rdata;
  logic              s_err;
  logic [EW:0]       vl = '0;
  logic              rd_start = 1'b0;
  logic [VW-1:0]     rd_vreg = '0;
  logic              rd_busy, rd_valid, rd_last, rd_done;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic [EW-1:0]     rd_idx;
  logic              wr_start = 1'b0;
  logic [VW-1:0]     wr_vreg = '0;
  logic              wr_busy, wr_ready, wr_done;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_mask = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] exp_mem [NREG][NELEM];
  logic [DATA_W-1:0] wd_q[$];
  bit                wm_q[$];

  vector_regfile_stream #(
    .DATA_W(DATA_W), .NREG(NREG), .NELEM(NELEM), .IOTA_REG(IOTA_REG)
  ) dut (
    .clk(clk), .reset(reset),
    .s_we(s_we), .s_vreg(s_vreg), .s_idx(s_idx), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_err(s_err),
    .vl(vl),
    .rd_start(rd_start), .rd_vreg(rd_vreg), .rd_busy(rd_busy),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_idx(rd_idx), .rd_last(rd_last), .rd_done(rd_done),
    .wr_start(wr_start), .wr_vreg(wr_vreg), .wr_busy(wr_busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scalar_read(input int v, input int i);
    s_vreg = VW'(v);
    s_idx  = EW'(i);
    step();
    check($sformatf("s_rd[%0d][%0d]", v, i), s_rdata, exp_mem[v][i]);
  endtask

  task automatic scalar_write(input int v, input int i, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] old;
    old     = exp_mem[v][i];
    s_vreg  = VW'(v);
    s_idx   = EW'(i);
    s_wdata = d;
    s_we    = 1'b1;
    step();
    s_we = 1'b0;
    check("s_wr_same_cycle_old", s_rdata, old);
    check("s_wr_no_err", s_err, 1'b0);
    exp_mem[v][i] = d;
    step();
    check("s_wr_visible", s_rdata, d);
  endtask

  task automatic wr_stream(input int v, input int vl_in, input bit rnd,
                           input int abort_at, input bit poke);
    int eff, k, guard;
    logic [DATA_W-1:0] d;
    bit m, poked;
    eff   = (vl_in > NELEM) ? NELEM : vl_in;
    poked = 1'b0;
    wr_vreg  = VW'(v);
    vl       = (EW + 1)'(vl_in);
    wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    if (eff == 0) begin
      check("wr0_busy", wr_busy, 1'b0);
      check("wr0_done", wr_done, 1'b1);
      step();
      check("wr0_done_fall", wr_done, 1'b0);
      return;
    end
    k = 0;
    guard = 0;
    while (k < eff && guard < 2000) begin
      check("wr_busy", wr_busy, 1'b1);
      check("wr_ready", wr_ready, 1'b1);
      check("wr_done_early", wr_done, 1'b0);
      if (k == abort_at) begin
        wr_valid = 1'b0;
        reset = 1'b0;
        step();
        check("wr_abort_busy", wr_busy, 1'b0);
        check("wr_abort_ready", wr_ready, 1'b0);
        reset = 1'b1;
        return;
      end
      wr_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = $urandom;
      m = $urandom_range(0, 1);
      if (wr_valid && wd_q.size() > 0) d = wd_q.pop_front();
      if (wr_valid && wm_q.size() > 0) m = wm_q.pop_front();
      wr_data = d;
      wr_mask = m;
      if (poke && !poked) begin
        s_we    = 1'b1;
        s_vreg  = 3'd5;
        s_idx   = 6'd7;
        s_wdata = $urandom;
      end
      step();
      if (poke && !poked) begin
        s_we  = 1'b0;
        poked = 1'b1;
        check("s_err_drop", s_err, 1'b1);
      end
      if (wr_valid) begin
        if (m) exp_mem[v][k] = d;
        k++;
      end
      guard++;
    end
    wr_valid = 1'b0;
    check("wr_timeout", guard < 2000, 1'b1);
    check("wr_done", wr_done, 1'b1);
    check("wr_busy_end", wr_busy, 1'b0);
    step();
    check("wr_done_pulse", wr_done, 1'b0);
  endtask

  task automatic rd_stream(input int v, input int vl_in, input int mode,
                           input int abort_at, input bit scal);
    int eff, k, guard, c, si;
    logic [DATA_W-1:0] exp_cur, sd;
    bit rdy, sw;
    bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    eff      = (vl_in > NELEM) ? NELEM : vl_in;
    rd_vreg  = VW'(v);
    vl       = (EW + 1)'(vl_in);
    rd_start = 1'b1;
    rd_ready = 1'b0;
    exp_cur  = exp_mem[v][0];
    step();
    rd_start = 1'b0;
    if (eff == 0) begin
      check("rd0_busy", rd_busy, 1'b0);
      check("rd0_valid", rd_valid, 1'b0);
      check("rd0_done", rd_done, 1'b1);
      step();
      check("rd0_done_fall", rd_done, 1'b0);
      return;
    end
    k = 0;
    c = 0;
    guard = 0;
    while (k < eff && guard < 2000) begin
      check("rd_valid", rd_valid, 1'b1);
      check("rd_busy", rd_busy, 1'b1);
      check("rd_idx", rd_idx, k);
      check($sformatf("rd_data[%0d]", k), rd_data, exp_cur);
      check("rd_last", rd_last, k == eff - 1);
      check("rd_done_early", rd_done, 1'b0);
      if (k == abort_at) begin
        rd_ready = 1'b0;
        reset = 1'b0;
        step();
        check("rd_abort_busy", rd_busy, 1'b0);
        check("rd_abort_valid", rd_valid, 1'b0);
        reset = 1'b1;
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[c % 5];
        default: rdy = $urandom_range(0, 1);
      endcase
      rd_ready = rdy;
      sw = scal && ($urandom_range(0, 1) == 1);
      si = 0;
      sd = '0;
      if (sw) begin
        si      = $urandom_range(0, eff - 1);
        sd      = $urandom;
        s_vreg  = VW'(v);
        s_idx   = EW'(si);
        s_wdata = sd;
        s_we    = 1'b1;
      end
      step();
      s_we = 1'b0;
      if (rdy) begin
        k++;
        if (k < eff) exp_cur = exp_mem[v][k];
      end
      if (sw) exp_mem[v][si] = sd;
      c++;
      guard++;
    end
    rd_ready = 1'b0;
    check("rd_timeout", guard < 2000, 1'b1);
    check("rd_done", rd_done, 1'b1);
    check("rd_busy_end", rd_busy, 1'b0);
    check("rd_valid_end", rd_valid, 1'b0);
    step();
    check("rd_done_pulse", rd_done, 1'b0);
  endtask

  initial begin
    for (int r = 0; r < NREG; r++)
      for (int e = 0; e < NELEM; e++)
        exp_mem[r][e] = (r == IOTA_REG) ? DATA_W'(e) : '0;

    // Reset with a non-zero read address so a missing output reset shows.
    s_vreg = 3'd1;
    s_idx  = 6'd5;
    repeat (2) step();
    check("rst_s_rdata", s_rdata, 0);
    check("rst_s_err", s_err, 0);
    check("rst_rd_busy", rd_busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_idx", rd_idx, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_rd_done", rd_done, 0);
    check("rst_wr_busy", wr_busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_wr_done", wr_done, 0);
    reset = 1'b1;

    scalar_read(1, 5);
    scalar_read(1, 63);
    scalar_read(2, 0);

    wd_q = '{32'd10, 32'd11, 32'd12, 32'd13};
    wm_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    wr_stream(3, 4, 1'b0, -1, 1'b0);
    for (int i = 0; i < 4; i++) scalar_read(3, i);

    rd_stream(1, 8, 1, -1, 1'b0);

    wr_stream(4, 0, 1'b0, -1, 1'b0);
    rd_stream(4, 0, 0, -1, 1'b0);

    wr_stream(6, 100, 1'b1, -1, 1'b0);
    rd_stream(6, 100, 2, -1, 1'b0);

    rd_stream(3, 16, 2, -1, 1'b1);

    wr_stream(5, 4, 1'b0, -1, 1'b1);
    scalar_read(5, 7);
    scalar_write(5, 7, $urandom);

    rd_stream(1, 8, 0, 3, 1'b0);
    wm_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    wr_stream(2, 8, 1'b0, 2, 1'b0);
    wm_q.delete();
    for (int i = 0; i < 4; i++) scalar_read(2, i);
    rd_stream(2, 4, 0, -1, 1'b0);
    wr_stream(7, 3, 1'b0, -1, 1'b0);

    for (int it = 0; it < 6; it++) begin
      int v;
      v = $urandom_range(0, NREG - 1);
      wr_stream(v, $urandom_range(0, 70), 1'b1, -1, 1'b0);
      rd_stream(v, $urandom_range(0, 70), 2, -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
